// File: rtl/pulse_meter.sv
// pulse_meter
//   Measures the high-phase and low-phase lengths of an asynchronous
//   waveform in clk cycles. After the first rising edge arms the
//   measurement, every later rising edge publishes the lengths of the
//   period that just completed. A phase that outlasts the counter range
//   aborts the measurement with a one-cycle timeout pulse.
//
// Ports
//   clk      : system clock, rising edge active
//   rst      : asynchronous active-high reset
//   en       : measurement enable (synchronous to clk)
//   sig_in   : waveform under measurement (asynchronous to clk)
//   hw_width : high-phase length of the last complete period
//   lw_width : low-phase length of the last complete period
//   period   : hw_width + lw_width, one bit wider so it never truncates
//   valid    : one-cycle pulse when the three results update
//   timeout  : one-cycle pulse when a phase overflows the counter
module pulse_meter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sig_in,
  output logic [CW-1:0] hw_width,
  output logic [CW-1:0] lw_width,
  output logic [CW:0]   period,
  output logic          valid,
  output logic          timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic          s1;
  logic          s2;
  logic          s3;
  logic          rise;
  logic          fall;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hw_reg;

  // s1/s2 resolve metastability; s3 is the previous synchronized level.
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Synchronizer and edge-detect delay line; runs regardless of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Measurement FSM with phase counter and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= CNT_ZERO;
      hw_reg   <= CNT_ZERO;
      hw_width <= CNT_ZERO;
      lw_width <= CNT_ZERO;
      period   <= {(CW+1){1'b0}};
      valid    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      if (!en) begin
        // Results hold; the next enable restarts from an unarmed IDLE.
        state <= IDLE;
        cnt   <= CNT_ZERO;
      end else begin
        case (state)
          IDLE: begin
            // A fall seen here has no preceding rise and is ignored.
            if (rise) begin
              state <= HIGH;
              cnt   <= CNT_ONE;
            end else begin
              cnt <= CNT_ZERO;
            end
          end
          HIGH: begin
            // The terminating edge wins over an overflow in the same cycle.
            if (fall) begin
              hw_reg <= cnt;
              cnt    <= CNT_ONE;
              state  <= LOW;
            end else if (cnt == CNT_MAX) begin
              timeout <= 1'b1;
              cnt     <= CNT_ZERO;
              state   <= IDLE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          LOW: begin
            if (rise) begin
              hw_width <= hw_reg;
              lw_width <= cnt;
              period   <= {1'b0, hw_reg} + {1'b0, cnt};
              valid    <= 1'b1;
              cnt      <= CNT_ONE;
              state    <= HIGH;
            end else if (cnt == CNT_MAX) begin
              timeout <= 1'b1;
              cnt     <= CNT_ZERO;
              state   <= IDLE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= CNT_ZERO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
module tb_pulse_meter;

  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;
  localparam int OW   = 3 * CW + 3;

  logic          clk;
  logic          rst;
  logic          en;
  logic          sig_in;
  logic [CW-1:0] hw_width;
  logic [CW-1:0] lw_width;
  logic [CW:0]   period;
  logic          valid;
  logic          timeout;

  int vectors;
  int miscompares;

  pulse_meter #(.CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sig_in   (sig_in),
    .hw_width (hw_width),
    .lw_width (lw_width),
    .period   (period),
    .valid    (valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: works on edge timestamps. A level change on sig_in
  // sampled at edge j is acted on at edge j+2. A period is reported at the
  // rise that ends it; a phase lasting MAXC edges without its closing edge
  // times out.
  localparam int PH_NONE = 0;
  localparam int PH_HI   = 1;
  localparam int PH_LO   = 2;

  logic [2:0]    hist;
  int            cyc;
  int            t_start;
  int            hi_len;
  int            m_phase;
  logic          exp_valid;
  logic          exp_to;
  logic [CW-1:0] exp_hw;
  logic [CW-1:0] exp_lw;
  logic [CW:0]   exp_per;
  logic          m_rise;
  logic          m_fall;

  assign m_rise = hist[1] & ~hist[2];
  assign m_fall = ~hist[1] & hist[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist      <= 3'b000;
      cyc       <= 0;
      t_start   <= 0;
      hi_len    <= 0;
      m_phase   <= PH_NONE;
      exp_valid <= 1'b0;
      exp_to    <= 1'b0;
      exp_hw    <= '0;
      exp_lw    <= '0;
      exp_per   <= '0;
    end else begin
      hist      <= {hist[1:0], sig_in};
      cyc       <= cyc + 1;
      exp_valid <= 1'b0;
      exp_to    <= 1'b0;
      if (!en) begin
        m_phase <= PH_NONE;
      end else if (m_phase == PH_NONE) begin
        if (m_rise) begin
          m_phase <= PH_HI;
          t_start <= cyc;
        end
      end else if (m_phase == PH_HI) begin
        if (m_fall) begin
          hi_len  <= cyc - t_start;
          t_start <= cyc;
          m_phase <= PH_LO;
        end else if (cyc - t_start == MAXC) begin
          exp_to  <= 1'b1;
          m_phase <= PH_NONE;
        end
      end else begin
        if (m_rise) begin
          exp_valid <= 1'b1;
          exp_hw    <= CW'(hi_len);
          exp_lw    <= CW'(cyc - t_start);
          exp_per   <= (CW+1)'(hi_len + cyc - t_start);
          t_start   <= cyc;
          m_phase   <= PH_HI;
        end else if (cyc - t_start == MAXC) begin
          exp_to  <= 1'b1;
          m_phase <= PH_NONE;
        end
      end
    end
  end

  logic [OW-1:0] obs;
  logic [OW-1:0] expv;
  assign obs  = {valid, timeout, hw_width, lw_width, period};
  assign expv = {exp_valid, exp_to, exp_hw, exp_lw, exp_per};

  // Apply one input level for one clock, ending at the next falling edge.
  task automatic step(input logic s);
    sig_in = s;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    sig_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      vectors++;
      if (obs !== '0) begin
        miscompares++;
        $display("FAIL reset_state: got %h want 0", obs);
      end
    end
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL reset_idle: got %h want %h", obs, expv);
      end
    end
  endtask

  task automatic test_square(input int hi, input int lo, input int reps);
    for (int p = 0; p < reps; p++) begin
      for (int i = 0; i < hi + lo; i++) begin
        step(i < hi);
        vectors++;
        if (obs !== expv) begin
          miscompares++;
          $display("FAIL square_%0d_%0d: got %h want %h", hi, lo, obs, expv);
        end
      end
    end
    vectors++;
    if (hw_width !== CW'(hi) || lw_width !== CW'(lo) || period !== (CW+1)'(hi + lo)) begin
      miscompares++;
      $display("FAIL square_result_%0d_%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
               hi, lo, hw_width, lw_width, period, hi, lo, hi + lo);
    end
  endtask

  task automatic test_timeout();
    int nv;
    int nt;
    nv = 0;
    nt = 0;
    en = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0);
    en = 1'b1;
    for (int i = 0; i < 10 + 300; i++) begin
      step(i >= 10);
      if (valid) nv++;
      if (timeout) nt++;
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL timeout_run: got %h want %h", obs, expv);
      end
    end
    vectors++;
    if (nt !== 1 || nv !== 0) begin
      miscompares++;
      $display("FAIL timeout_count: got %0d timeouts %0d valids want 1 and 0", nt, nv);
    end
    nv = 0;
    for (int i = 0; i < 20 + 20 + 20 + 10; i++) begin
      step((i >= 20 && i < 40) || i >= 60);
      if (valid) nv++;
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL timeout_recover: got %h want %h", obs, expv);
      end
    end
    vectors++;
    if (nv !== 1 || hw_width !== CW'(20) || lw_width !== CW'(20)) begin
      miscompares++;
      $display("FAIL timeout_fresh: got %0d valids %0d/%0d want 1 valid 20/20", nv, hw_width, lw_width);
    end
  endtask

  task automatic test_max_high();
    int nt;
    nt = 0;
    en = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0);
    en = 1'b1;
    for (int i = 0; i < 10 + 255 + 30 + 10; i++) begin
      step((i >= 10 && i < 265) || i >= 295);
      if (timeout) nt++;
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL max_high_run: got %h want %h", obs, expv);
      end
    end
    vectors++;
    if (nt !== 0 || hw_width !== CW'(255) || lw_width !== CW'(30) || period !== (CW+1)'(285)) begin
      miscompares++;
      $display("FAIL max_high_result: got to=%0d %0d/%0d/%0d want 0 255/30/285",
               nt, hw_width, lw_width, period);
    end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 2 * 80 + 60; i++) begin
      step((i % 80) < 40);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL rst_mid_pre: got %h want %h", obs, expv);
      end
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_clear: got %h want 0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20 + 3 * 50; i++) begin
      step(i >= 20 && ((i - 20) % 50) < 25);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL rst_mid_post: got %h want %h", obs, expv);
      end
    end
  endtask

  task automatic test_en_drop();
    int nev;
    nev = 0;
    for (int i = 0; i < 3 * 60 + 20; i++) begin
      en = !(i >= 140 && i < 150);
      step((i % 60) < 30);
      if (i >= 140 && i < 155 && (valid || timeout)) nev++;
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL en_drop_run: got %h want %h", obs, expv);
      end
    end
    en = 1'b1;
    vectors++;
    if (nev !== 0) begin
      miscompares++;
      $display("FAIL en_drop_quiet: got %0d events want 0", nev);
    end
    for (int i = 0; i < 2 * 60 + 10; i++) begin
      step((i % 60) < 30);
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL en_drop_after: got %h want %h", obs, expv);
      end
    end
  endtask

  task automatic test_random();
    int hi;
    int lo;
    for (int p = 0; p < 40; p++) begin
      hi = int'($urandom_range(1, 60));
      lo = int'($urandom_range(1, 60));
      for (int i = 0; i < hi + lo; i++) begin
        en = ($urandom_range(0, 199) != 0);
        step(i < hi);
        vectors++;
        if (obs !== expv) begin
          miscompares++;
          $display("FAIL random_p%0d: got %h want %h", p, obs, expv);
        end
      end
    end
    en = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    en     = 1'b0;
    sig_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_square(50, 50, 4);
    test_square(30, 70, 3);
    test_square(1, 1, 6);
    test_timeout();
    test_max_high();
    test_rst_mid();
    test_en_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
